// File: rtl/fft_frame_collector.sv
// Ping-pong frame buffer: collects an unordered, non-stallable FFT sample stream
// into one bank while the other bank is replayed in natural order on a valid/ready port.
module fft_frame_collector #(
  parameter int ADDR_W = 8,
  parameter int RE_W   = 16,
  parameter int IM_W   = 16
) (
  input  logic              iclk,
  input  logic              rst,
  input  logic              ien,
  input  logic [ADDR_W-1:0] iaddr,
  input  logic [RE_W-1:0]   iReal,
  input  logic [IM_W-1:0]   iImag,
  output logic              ovalid,
  input  logic              oready,
  output logic [ADDR_W-1:0] oaddr,
  output logic [RE_W-1:0]   oReal,
  output logic [IM_W-1:0]   oImag,
  output logic              olast,
  output logic              oerr,
  input  logic              ierr_clr
);

  localparam int N  = 1 << ADDR_W;
  localparam int DW = RE_W + IM_W;

  typedef enum logic [1:0] {
    S_IDLE,
    S_PRIME,
    S_STREAM
  } state_e;

  logic [DW-1:0]     mem [2*N];
  logic [DW-1:0]     rdata_q;
  logic [ADDR_W:0]   raddr_d;

  logic              wbank_q;
  logic [ADDR_W-1:0] wcnt_q;
  logic [1:0]        full_q;
  logic [1:0]        full_d;
  logic              oerr_q;

  state_e            state_q;
  logic              rbank_q;
  logic              ovalid_q;
  logic              olast_q;
  logic [ADDR_W-1:0] oaddr_q;
  logic [DW-1:0]     odata_q;

  logic              wr_acc;
  logic              wr_drop;
  logic              wr_done;
  logic              hs;
  logic              rd_release;

  assign wr_acc     = ien & ~full_q[wbank_q];
  assign wr_drop    = ien &  full_q[wbank_q];
  assign wr_done    = wr_acc & (wcnt_q == '1);
  assign hs         = ovalid_q & oready;
  assign rd_release = hs & olast_q;

  // Reader only clears a full bank and writer only sets an empty one, so both
  // updates on the same edge always target different banks.
  always_comb begin
    full_d = full_q;
    if (rd_release) full_d[rbank_q] = 1'b0;
    if (wr_done)    full_d[wbank_q] = 1'b1;
  end

  always_ff @(posedge iclk or posedge rst) begin
    if (rst) begin
      wbank_q <= 1'b0;
      wcnt_q  <= '0;
      full_q  <= '0;
      oerr_q  <= 1'b0;
    end else begin
      full_q <= full_d;
      if (wr_acc) begin
        wcnt_q <= wcnt_q + ADDR_W'(1);
        if (wr_done) wbank_q <= ~wbank_q;
      end
      if (wr_drop)       oerr_q <= 1'b1;
      else if (ierr_clr) oerr_q <= 1'b0;
    end
  end

  always_ff @(posedge iclk) begin
    if (wr_acc) mem[{wbank_q, iaddr}] <= {iReal, iImag};
    rdata_q <= mem[raddr_d];
  end

  // The read address always points one word ahead of the output register;
  // holding it while stalled keeps the prefetched word in rdata_q.
  always_comb begin
    raddr_d = {rbank_q, oaddr_q + ADDR_W'(1)};
    case (state_q)
      S_IDLE:  raddr_d = {rbank_q, ADDR_W'(0)};
      S_PRIME: raddr_d = {rbank_q, ADDR_W'(1)};
      S_STREAM: begin
        if (hs) begin
          if (olast_q) raddr_d = {~rbank_q, ADDR_W'(0)};
          else         raddr_d = {rbank_q, oaddr_q + ADDR_W'(2)};
        end
      end
      default: raddr_d = {rbank_q, ADDR_W'(0)};
    endcase
  end

  always_ff @(posedge iclk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      rbank_q  <= 1'b0;
      ovalid_q <= 1'b0;
      olast_q  <= 1'b0;
      oaddr_q  <= '0;
      odata_q  <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (full_q[rbank_q]) state_q <= S_PRIME;
        end
        S_PRIME: begin
          ovalid_q <= 1'b1;
          oaddr_q  <= '0;
          odata_q  <= rdata_q;
          olast_q  <= 1'b0;
          state_q  <= S_STREAM;
        end
        S_STREAM: begin
          if (hs) begin
            if (olast_q) begin
              ovalid_q <= 1'b0;
              olast_q  <= 1'b0;
              rbank_q  <= ~rbank_q;
              // Next bank already complete: skip IDLE, its word 0 is being read now.
              state_q  <= full_q[~rbank_q] ? S_PRIME : S_IDLE;
            end else begin
              odata_q <= rdata_q;
              oaddr_q <= oaddr_q + ADDR_W'(1);
              olast_q <= (oaddr_q == ADDR_W'(N - 2));
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign ovalid = ovalid_q;
  assign oaddr  = oaddr_q;
  assign oReal  = odata_q[DW-1:IM_W];
  assign oImag  = odata_q[IM_W-1:0];
  assign olast  = olast_q;
  assign oerr   = oerr_q;

endmodule

// File: tb/tb_fft_frame_collector.sv
// Directed bench for fft_frame_collector with N=8: bit-reversed frames in,
// natural-order frames out, stalls, overflow, reset and error-clear cases.
module tb_fft_frame_collector;

  localparam int AW = 3;
  localparam int N  = 8;

  logic          iclk = 1'b0;
  logic          rst, ien, oready, ierr_clr;
  logic [AW-1:0] iaddr, oaddr;
  logic [15:0]   iReal, iImag, oReal, oImag;
  logic          ovalid, olast, oerr;

  int checks = 0;
  int errors = 0;

  fft_frame_collector #(.ADDR_W(AW), .RE_W(16), .IM_W(16)) dut (
    .iclk(iclk), .rst(rst), .ien(ien), .iaddr(iaddr), .iReal(iReal), .iImag(iImag),
    .ovalid(ovalid), .oready(oready), .oaddr(oaddr), .oReal(oReal), .oImag(oImag),
    .olast(olast), .oerr(oerr), .ierr_clr(ierr_clr)
  );

  always #5 iclk = ~iclk;

  function automatic logic [15:0] exp_re(int f, int a);
    return 16'(f * 4096 + a * 257);
  endfunction

  function automatic int br(int i);
    return ((i & 1) << 2) | (i & 2) | ((i >> 2) & 1);
  endfunction

  task automatic put(int f, int a);
    ien   = 1'b1;
    iaddr = AW'(a);
    iReal = exp_re(f, a);
    iImag = ~exp_re(f, a);
  endtask

  task automatic test_reset;
    @(negedge iclk);
    checks++;
    if ({ovalid, oaddr, oReal, oImag, olast, oerr} !== '0) begin
      errors++;
      $display("FAIL reset_state: got %h required 0", {ovalid, oaddr, oReal, oImag, olast, oerr});
    end
    rst = 1'b0;
  endtask

  task automatic test_single_frame;
    oready = 1'b1;
    for (int k = 0; k < N; k++) begin
      @(negedge iclk);
      put(0, br(k));
    end
    @(negedge iclk);
    ien = 1'b0;
    checks++;
    if (ovalid !== 1'b0) begin errors++; $display("FAIL single_lat1: ovalid got %b required 0", ovalid); end
    @(negedge iclk);
    checks++;
    if (ovalid !== 1'b0) begin errors++; $display("FAIL single_lat2: ovalid got %b required 0", ovalid); end
    for (int i = 0; i < N; i++) begin
      @(negedge iclk);
      checks++;
      if (ovalid !== 1'b1) begin errors++; $display("FAIL single_valid[%0d]: got %b required 1", i, ovalid); end
      checks++;
      if (oaddr !== AW'(i)) begin errors++; $display("FAIL single_addr[%0d]: got %0d required %0d", i, oaddr, i); end
      checks++;
      if ({oReal, oImag} !== {exp_re(0, i), ~exp_re(0, i)}) begin
        errors++;
        $display("FAIL single_data[%0d]: got %h_%h required %h_%h", i, oReal, oImag, exp_re(0, i), ~exp_re(0, i));
      end
      checks++;
      if (olast !== (i == N - 1)) begin errors++; $display("FAIL single_last[%0d]: got %b", i, olast); end
    end
    @(negedge iclk);
    checks++;
    if (ovalid !== 1'b0) begin errors++; $display("FAIL single_end: ovalid got %b required 0", ovalid); end
    checks++;
    if (oerr !== 1'b0) begin errors++; $display("FAIL single_oerr: got %b required 0", oerr); end
  endtask

  task automatic test_back_to_back;
    int cnt = 0;
    oready = 1'b1;
    for (int c = 0; c < 60; c++) begin
      @(negedge iclk);
      if (c < 2 * N) put(1 + c / N, br(c % N));
      else ien = 1'b0;
      if (ovalid) begin
        checks++;
        if (oaddr !== AW'(cnt % N) || olast !== (cnt % N == N - 1) ||
            {oReal, oImag} !== {exp_re(1 + cnt / N, cnt % N), ~exp_re(1 + cnt / N, cnt % N)}) begin
          errors++;
          $display("FAIL b2b_out[%0d]: got addr %0d last %b data %h_%h required addr %0d data %h",
                   cnt, oaddr, olast, oReal, oImag, cnt % N, exp_re(1 + cnt / N, cnt % N));
        end
        cnt++;
      end
    end
    checks++;
    if (cnt !== 2 * N) begin errors++; $display("FAIL b2b_count: got %0d required %0d", cnt, 2 * N); end
    checks++;
    if (oerr !== 1'b0) begin errors++; $display("FAIL b2b_oerr: got %b required 0", oerr); end
  endtask

  task automatic test_stall;
    int hs = 0;
    logic prev_stall = 1'b0;
    logic [36:0] prev = '0;
    oready = 1'b0;
    for (int k = 0; k < N; k++) begin
      @(negedge iclk);
      put(3, br(k));
    end
    @(negedge iclk);
    ien = 1'b0;
    for (int c = 0; c < 60; c++) begin
      @(negedge iclk);
      oready = (c % 2 == 0);
      if (ovalid) begin
        if (prev_stall) begin
          checks++;
          if ({oaddr, oReal, oImag, olast} !== prev) begin
            errors++;
            $display("FAIL stall_stable[c%0d]: got %h required %h", c, {oaddr, oReal, oImag, olast}, prev);
          end
        end
        if (oready) begin
          checks++;
          if (oaddr !== AW'(hs) || olast !== (hs == N - 1) || {oReal, oImag} !== {exp_re(3, hs), ~exp_re(3, hs)}) begin
            errors++;
            $display("FAIL stall_out[%0d]: got addr %0d last %b data %h required addr %0d data %h",
                     hs, oaddr, olast, oReal, hs, exp_re(3, hs));
          end
          hs++;
        end
      end
      prev_stall = ovalid && !oready;
      prev = {oaddr, oReal, oImag, olast};
    end
    checks++;
    if (hs !== N) begin errors++; $display("FAIL stall_count: got %0d required %0d", hs, N); end
  endtask

  task automatic test_overflow;
    int cnt = 0;
    oready = 1'b0;
    for (int c = 0; c < 3 * N; c++) begin
      @(negedge iclk);
      put(4 + c / N, br(c % N));
    end
    @(negedge iclk);
    ien = 1'b0;
    checks++;
    if (oerr !== 1'b1) begin errors++; $display("FAIL ovf_oerr_set: got %b required 1", oerr); end
    checks++;
    if (ovalid !== 1'b1 || oaddr !== '0) begin
      errors++;
      $display("FAIL ovf_held: got valid %b addr %0d required 1/0", ovalid, oaddr);
    end
    for (int c = 0; c < 60; c++) begin
      @(negedge iclk);
      oready = 1'b1;
      if (ovalid) begin
        checks++;
        if (oaddr !== AW'(cnt % N) || {oReal, oImag} !== {exp_re(4 + cnt / N, cnt % N), ~exp_re(4 + cnt / N, cnt % N)}) begin
          errors++;
          $display("FAIL ovf_out[%0d]: got addr %0d data %h_%h required addr %0d data %h",
                   cnt, oaddr, oReal, oImag, cnt % N, exp_re(4 + cnt / N, cnt % N));
        end
        cnt++;
      end
    end
    checks++;
    if (cnt !== 2 * N) begin errors++; $display("FAIL ovf_count: got %0d required %0d", cnt, 2 * N); end
    checks++;
    if (oerr !== 1'b1) begin errors++; $display("FAIL ovf_oerr_sticky: got %b required 1", oerr); end
    @(negedge iclk);
    ierr_clr = 1'b1;
    @(negedge iclk);
    ierr_clr = 1'b0;
    checks++;
    if (oerr !== 1'b0) begin errors++; $display("FAIL ovf_oerr_clr: got %b required 0", oerr); end
  endtask

  task automatic test_reset_midway;
    int  cnt;
    logic found = 1'b0;
    oready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge iclk);
      put(7, br(k));
    end
    @(negedge iclk);
    ien = 1'b0;
    rst = 1'b1;
    #1;
    checks++;
    if ({ovalid, oaddr, oReal, oImag, olast, oerr} !== '0) begin
      errors++;
      $display("FAIL rst_write_outs: got %h required 0", {ovalid, oaddr, oReal, oImag, olast, oerr});
    end
    @(negedge iclk);
    rst = 1'b0;
    // Same frame loop twice: after the partial-frame reset and after the streaming reset.
    for (int pass = 0; pass < 2; pass++) begin
      cnt = 0;
      for (int c = 0; c < 30; c++) begin
        @(negedge iclk);
        if (c < N) put(8 + 2 * pass, br(c));
        else ien = 1'b0;
        if (ovalid) begin
          checks++;
          if (oaddr !== AW'(cnt) || {oReal, oImag} !== {exp_re(8 + 2 * pass, cnt), ~exp_re(8 + 2 * pass, cnt)}) begin
            errors++;
            $display("FAIL rst_frame%0d_out[%0d]: got addr %0d data %h_%h required data %h",
                     pass, cnt, oaddr, oReal, oImag, exp_re(8 + 2 * pass, cnt));
          end
          cnt++;
        end
      end
      checks++;
      if (cnt !== N) begin errors++; $display("FAIL rst_frame%0d_count: got %0d required %0d", pass, cnt, N); end
      if (pass == 0) begin
        for (int c = 0; c < 30 && !found; c++) begin
          @(negedge iclk);
          if (c < N) put(9, br(c));
          else ien = 1'b0;
          if (ovalid && oaddr == AW'(3)) found = 1'b1;
        end
        ien = 1'b0;
        checks++;
        if (found !== 1'b1) begin errors++; $display("FAIL rst_stream_wait: got timeout required oaddr 3"); end
        rst = 1'b1;
        #1;
        checks++;
        if ({ovalid, oaddr, oReal, oImag, olast} !== '0) begin
          errors++;
          $display("FAIL rst_stream_outs: got %h required 0", {ovalid, oaddr, oReal, oImag, olast});
        end
        @(negedge iclk);
        rst = 1'b0;
        repeat (4) @(negedge iclk);
        checks++;
        if (ovalid !== 1'b0) begin errors++; $display("FAIL rst_stream_idle: ovalid got %b required 0", ovalid); end
      end
    end
  endtask

  task automatic test_err_clr_same_edge;
    int cnt = 0;
    oready = 1'b0;
    for (int c = 0; c < 2 * N; c++) begin
      @(negedge iclk);
      put(11 + c / N, br(c % N));
    end
    @(negedge iclk);
    put(0, 0);
    ierr_clr = 1'b1;
    @(negedge iclk);
    ien = 1'b0;
    checks++;
    if (oerr !== 1'b1) begin errors++; $display("FAIL same_edge_oerr: got %b required 1", oerr); end
    @(negedge iclk);
    ierr_clr = 1'b0;
    checks++;
    if (oerr !== 1'b0) begin errors++; $display("FAIL same_edge_clr_after: got %b required 0", oerr); end
    for (int c = 0; c < 60; c++) begin
      @(negedge iclk);
      oready = 1'b1;
      if (ovalid) begin
        checks++;
        if (oaddr !== AW'(cnt % N) || {oReal, oImag} !== {exp_re(11 + cnt / N, cnt % N), ~exp_re(11 + cnt / N, cnt % N)}) begin
          errors++;
          $display("FAIL same_edge_out[%0d]: got addr %0d data %h_%h required data %h",
                   cnt, oaddr, oReal, oImag, exp_re(11 + cnt / N, cnt % N));
        end
        cnt++;
      end
    end
    checks++;
    if (cnt !== 2 * N) begin errors++; $display("FAIL same_edge_count: got %0d required %0d", cnt, 2 * N); end
  endtask

  initial begin
    rst      = 1'b1;
    ien      = 1'b0;
    iaddr    = '0;
    iReal    = '0;
    iImag    = '0;
    oready   = 1'b0;
    ierr_clr = 1'b0;
    @(negedge iclk);
    test_reset;
    test_single_frame;
    test_back_to_back;
    test_stall;
    test_overflow;
    test_reset_midway;
    test_err_clr_same_edge;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fft_frame_collector.md
Name: fft_frame_collector

Overview:
- Consumes the unordered, non-stallable sample stream that the FFT/IFFT cores emit (en, addr, real, imag). Address order within a frame is arbitrary, e.g. bit-reversed.
- Buffers each frame in one half of a ping-pong memory.
- Replays complete frames in natural index order (0..N-1) on a valid/ready output interface.
- Sits between the ifft/fft output and downstream framing/DAC logic.

Parameters:
- ADDR_W, 8, log2 of frame length N (matches TOTAL_STAGE); N = 2^ADDR_W.
- RE_W, 16, real sample width (matches REAL_WIDTH).
- IM_W, 16, imaginary sample width (matches IMGN_WIDTH).

Ports:
- iclk  in  1  clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- ien  in  1  input sample strobe; cannot be back-pressured.
- iaddr  in  ADDR_W  frame index of input sample.
- iReal  in  RE_W  input real part.
- iImag  in  IM_W  input imaginary part.
- ovalid  out  1  output sample valid.
- oready  in  1  downstream ready.
- oaddr  out  ADDR_W  natural-order index of output sample.
- oReal  out  RE_W  output real part.
- oImag  out  IM_W  output imaginary part.
- olast  out  1  high with index N-1.
- oerr  out  1  sticky overflow flag.
- ierr_clr  in  1  synchronous clear of oerr.

Behaviour:
- Reset (async, rst=1): ovalid=0, oaddr=0, oReal=0, oImag=0, olast=0, oerr=0. Internal state wbank=0, rbank=0, full[1:0]=0, wcnt=0, read FSM=IDLE. Memory contents are not reset. Reset mid-frame discards both banks and any partially written frame.
- Memory: 2 banks x N words of RE_W+IM_W bits; synchronous write, synchronous read (1-cycle latency).
- Write side, ien=1 and full[wbank]=0:
  - mem[wbank][iaddr] <= {iReal, iImag}; wcnt++.
  - On the N-th write: full[wbank]<=1, wbank toggles, wcnt<=0 (same edge).
- Write side, ien=1 and full[wbank]=1: sample dropped, wcnt unchanged, oerr<=1.
- Write side, duplicate addresses: not detected. Each write counts toward N; last write wins. Unwritten locations hold stale data.
- oerr: sticky. ierr_clr=1 clears it unless an overflow occurs on the same edge; set wins.
- Read FSM states:
  - IDLE: if full[rbank]=1, go to PRIME; issue read of index 0.
  - PRIME: load output register from memory; ovalid<=1, oaddr=0. Go to STREAM; pre-issue read of index 1.
  - STREAM: output register holds the current sample.
    - On handshake (ovalid&oready) with oaddr<N-1: output register takes the prefetched word; oaddr++; next read issued.
    - Without handshake: output stays stable; no prefetch advance (prefetch register or read-address hold required).
    - Handshake with olast=1: ovalid<=0, full[rbank]<=0, rbank toggles, FSM to IDLE.
- Latency: last input write sampled at edge T gives ovalid=1 with oaddr=0 after edge T+2. With oready held high, one sample per cycle; N consecutive valid cycles; 1 idle cycle minimum between frames.
- olast = ovalid & (oaddr==N-1).
- Output signals must not change while ovalid=1 and oready=0.
- Simultaneous events:
  - Writer filling bank A while reader drains bank B is legal every cycle.
  - full[rbank] clear and full[wbank] set on the same edge act on different banks; both take effect.
  - Writer blocked on a full bank resumes on the cycle after the reader releases it (the edge of the final handshake).
- Widths: no arithmetic on data; samples pass bit-exact.

Test Plan (ADDR_W=3, N=8):
- Write 8 samples at bit-reversed addresses 0,4,2,6,1,5,3,7 with data = 0x0100*addr + addr, oready=1 -> ovalid rises 2 edges after last write; oaddr 0..7 on consecutive cycles, data matching; olast only at oaddr=7.
- Two back-to-back frames (16 consecutive ien cycles), oready=1 -> both frames output in order with no drops, oerr=0.
- oready toggled 1-0-1-0 during output -> each index presented exactly once; outputs stable while stalled; 8 handshakes total.
- oready=0, write 3 full frames (24 samples) -> first 16 accepted, next 8 dropped, oerr=1. Then oready=1 -> exactly frames 1 and 2 output. Pulse ierr_clr -> oerr=0.
- Assert rst while 5 of 8 samples are written and during output streaming -> all outputs 0 immediately; a following full frame outputs correctly starting at oaddr=0.
- ierr_clr and an overflow on the same edge -> oerr remains 1.
